// File: rtl/button_pkg.sv
// ============================================================================
// button_pkg : shared constants and helpers for the push-button debouncer
// Revision   : 1.0
// ============================================================================
`default_nettype none

package button_pkg;

  // PMOD buttons pull the pin low while held.
  localparam logic BTN_ACTIVE = 1'b0;

  // 20 ms at a 12 MHz system clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 240000;

  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage : button_pkg

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// debounce_channel : synchronizer, stability counter, level and pulse flops
//                    for a single active-low button pin
// Revision         : 1.0
// ============================================================================
`default_nettype none

module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic pressed,
  output logic press,
  output logic release_pulse
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          raw;

  assign raw = (s2 == BTN_ACTIVE);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1            <= ~BTN_ACTIVE;
      s2            <= ~BTN_ACTIVE;
      pressed       <= 1'b0;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= pin;
      s2            <= s1;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      if (raw == pressed) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        pressed       <= raw;
        cnt           <= '0;
        press         <= raw;
        release_pulse <= ~raw;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule : debounce_channel

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// button_debouncer : NUM_BTN independent debounce channels for PMOD buttons
// Revision         : 1.0
// ============================================================================
`default_nettype none

module button_debouncer
  import button_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] pmod,
  output logic [NUM_BTN-1:0] pressed,
  output logic [NUM_BTN-1:0] press,
  // "release" is a reserved word in SystemVerilog, hence the suffix.
  output logic [NUM_BTN-1:0] release_pulse
);

  if (DEBOUNCE_CYCLES < 2) begin : g_param_check
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_channel
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_channel (
      .clk           (clk),
      .rst           (rst),
      .pin           (pmod[i]),
      .pressed       (pressed[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule : button_debouncer

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// ============================================================================
// tb_button_debouncer : scenario tasks plus randomized run against a
//                       window-based reference model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_button_debouncer;

  localparam int NB = 2;
  localparam int D  = 4;
  localparam logic [31:0] WIN = (32'd1 << D) - 32'd1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] pmod = '1;
  logic [NB-1:0] pressed;
  logic [NB-1:0] press;
  logic [NB-1:0] release_pulse;

  int errors = 0;
  int checks = 0;

  button_debouncer #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pmod          (pmod),
    .pressed       (pressed),
    .press         (press),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model: a level flips once the last D synchronized raw values
  // all disagree with it, where raw lags the pin by two samples.
  logic [NB-1:0] m_pressed = '0;
  logic [NB-1:0] m_press   = '0;
  logic [NB-1:0] m_release = '0;
  logic [1:0]    m_pins [NB];
  logic [31:0]   m_hist [NB];
  logic [31:0]   m_valid[NB];

  always @(posedge clk) begin
    for (int ch = 0; ch < NB; ch++) begin
      if (rst) begin
        m_pins[ch]    = 2'b11;
        m_hist[ch]    = '0;
        m_valid[ch]   = '0;
        m_pressed[ch] = 1'b0;
        m_press[ch]   = 1'b0;
        m_release[ch] = 1'b0;
      end else begin
        logic raw;
        raw           = ~m_pins[ch][1];
        m_hist[ch]    = {m_hist[ch][30:0], raw};
        m_valid[ch]   = {m_valid[ch][30:0], 1'b1};
        m_press[ch]   = 1'b0;
        m_release[ch] = 1'b0;
        if ((m_valid[ch] & WIN) == WIN &&
            (m_hist[ch] & WIN) == (m_pressed[ch] ? 32'd0 : WIN)) begin
          m_pressed[ch] = ~m_pressed[ch];
          m_press[ch]   = m_pressed[ch];
          m_release[ch] = ~m_pressed[ch];
          m_valid[ch]   = '0;
        end
        m_pins[ch] = {m_pins[ch][0], pmod[ch]};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    pmod = 2'b11;
    repeat (3) tick();
    checks++;
    if ({pressed, press, release_pulse} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: pressed=%b press=%b release=%b required all 00",
               pressed, press, release_pulse);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if ({pressed, press, release_pulse} !== 6'b0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: pressed=%b press=%b release=%b required 00",
                 k, pressed, press, release_pulse);
      end
    end
  endtask

  task automatic test_clean_press();
    pmod[0] = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      tick();
      checks++;
      if (pressed !== {1'b0, k >= 5} || press !== {1'b0, k == 5} ||
          release_pulse !== 2'b00) begin
        errors++;
        $display("FAIL clean_press edge%0d: pressed=%b press=%b release=%b required %b %b 00",
                 k, pressed, press, release_pulse, {1'b0, k >= 5}, {1'b0, k == 5});
      end
    end
  endtask

  task automatic test_glitch();
    pmod = 2'b11;
    repeat (8) tick();
    // Edges 0..2 low, edge 3 high, edge 4 onward low: accept at edge 9.
    for (int k = 0; k <= 12; k++) begin
      pmod[0] = (k == 3) ? 1'b1 : 1'b0;
      tick();
      checks++;
      if (pressed[0] !== (k >= 9) || press[0] !== (k == 9)) begin
        errors++;
        $display("FAIL glitch edge%0d: pressed0=%b press0=%b required %b %b",
                 k, pressed[0], press[0], k >= 9, k == 9);
      end
    end
  endtask

  task automatic test_release_both();
    pmod = 2'b00;
    repeat (10) tick();
    checks++;
    if (pressed !== 2'b11) begin
      errors++;
      $display("FAIL both_held: pressed=%b required 11", pressed);
    end
    pmod = 2'b11;
    for (int k = 0; k <= 8; k++) begin
      tick();
      checks++;
      if (release_pulse !== ((k == 5) ? 2'b11 : 2'b00) ||
          pressed !== ((k >= 5) ? 2'b00 : 2'b11) || press !== 2'b00) begin
        errors++;
        $display("FAIL release_both edge%0d: pressed=%b press=%b release=%b",
                 k, pressed, press, release_pulse);
      end
    end
  endtask

  task automatic test_reset_held();
    int n;
    pmod = 2'b01;
    n = 0;
    while (pressed[1] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (pressed[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_held_setup: pressed1=%b required 1 within 20 cycles", pressed[1]);
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (pressed[1] !== 1'b0 || release_pulse !== 2'b00) begin
      errors++;
      $display("FAIL reset_held_drop: pressed1=%b release=%b required 0 00",
               pressed[1], release_pulse);
    end
    rst = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      tick();
      checks++;
      if (release_pulse[1] !== 1'b0 || press[1] !== (k == 5) ||
          pressed[1] !== (k >= 5)) begin
        errors++;
        $display("FAIL reset_held_repress edge%0d: pressed1=%b press1=%b release1=%b",
                 k, pressed[1], press[1], release_pulse[1]);
      end
    end
  endtask

  task automatic test_long_hold();
    int pulses;
    pmod = 2'b11;
    repeat (8) tick();
    pulses  = 0;
    pmod[0] = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (press[0] === 1'b1) pulses++;
      checks++;
      if (pressed[0] !== (k >= 5) || release_pulse[0] !== 1'b0) begin
        errors++;
        $display("FAIL long_hold edge%0d: pressed0=%b release0=%b required %b 0",
                 k, pressed[0], release_pulse[0], k >= 5);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL long_hold_pulses: saw %0d press pulses required 1", pulses);
    end
  endtask

  task automatic test_random();
    int hold [NB];
    for (int ch = 0; ch < NB; ch++) hold[ch] = 0;
    for (int k = 0; k < 600; k++) begin
      for (int ch = 0; ch < NB; ch++) begin
        if (hold[ch] == 0) begin
          pmod[ch] = ~pmod[ch];
          hold[ch] = $urandom_range(1, 8);
        end
        hold[ch]--;
      end
      rst = ($urandom_range(0, 79) == 0);
      tick();
      checks++;
      if (pressed !== m_pressed || press !== m_press || release_pulse !== m_release ||
          (press & release_pulse) !== 2'b00) begin
        errors++;
        $display("FAIL random cyc%0d: got %b/%b/%b required %b/%b/%b",
                 k, pressed, press, release_pulse, m_pressed, m_press, m_release);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_release_both();
    test_reset_held();
    test_long_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_button_debouncer

`default_nettype wire

// File: doc/button_debouncer.md
# button_debouncer

Conditions raw, active-low push-button inputs from the PMOD header into clean, glitch-free signals for the fabric clock domain. Per button: two-flop synchronizer, consecutive-cycle debounce counter, debounced level, one-cycle press and release pulses. Sits between the PMOD pins and downstream logic such as the button counter, so that logic runs on the system clock with synchronous enables instead of clocking directly from a button.

## Interface
- `NUM_BTN`, default 2: number of independent button channels.
- `DEBOUNCE_CYCLES`, default 240000 (20 ms at 12 MHz): consecutive stable cycles required to accept a level change. Must be >= 2.
- `clk`  input  1: system clock. The block has one clock; every register is clocked on its rising edge.
- `rst`  input  1: synchronous, active-high reset, sampled on the `clk` rising edge.
- `pmod`  input  NUM_BTN: raw button pins, active-low (0 = pressed), asynchronous to `clk`.
- `pressed`  output  NUM_BTN: debounced level, active-high (1 = held).
- `press`  output  NUM_BTN: one-cycle pulse on each accepted press.
- `release`  output  NUM_BTN: one-cycle pulse on each accepted release.

## Operation
- Channels are fully independent. Channel i uses only `pmod[i]`.
- Synchronizer: `s1 <= pmod[i]`, `s2 <= s1`. The internal raw value is `raw = ~s2`, which is active-high.
- Debounce counter `cnt` has width `$clog2(DEBOUNCE_CYCLES)`. It counts only while `raw != pressed`.
- If `raw == pressed` in any cycle, `cnt <= 0` on the next edge. A glitch shorter than `DEBOUNCE_CYCLES` cycles therefore never changes the output, and the counter restarts from 0.
- If `raw != pressed` and `cnt == DEBOUNCE_CYCLES-1`:
  - `pressed <= raw` and `cnt <= 0`.
  - `press <= raw`, `release <= ~raw`.
- Otherwise, if `raw != pressed`: `cnt <= cnt + 1`.
- `press` and `release` are registered. Each is 1 only in the single cycle immediately after an accepted change, and 0 in every other cycle.
- Per channel, `press` and `release` are never high together.
- Reset values: `s1 = s2 = 1` (released), `pressed = 0`, `cnt = 0`, `press = 0`, `release = 0` on every channel.
- Reset priority: `rst` overrides all other updates.
- Reset mid-debounce: any partial count is discarded.
- Reset while a button is held: `pressed` drops to 0 with no `release` pulse. After `rst` deasserts, a pin still held low is re-accepted through the normal path and produces a fresh `press` pulse.
- Continuously held button: exactly one `press` pulse, no repeat.

## Timing
- Edge 0 is the first `clk` edge that samples the new pin value into `s1`.
  - `s2` changes at edge 1.
  - `cnt` increments at edges 2 .. D (D = `DEBOUNCE_CYCLES`), reaching D-1.
  - `pressed` and `press` (or `release`) update at edge D+1.
- End-to-end latency from pin change to output change is therefore D+1 edges.
- A stable pin produces no output activity.
- Maximum accepted toggle rate is one change per D+1 cycles per channel.
- No combinational path from `pmod` to any output. All outputs come directly from flops.
- Counter never exceeds D-1, so there is no wrap-around.

## Structure
- Shared package `button_pkg`:
  - active-low pin polarity constant `BTN_ACTIVE = 1'b0`.
  - default `DEBOUNCE_CYCLES` constant.
  - helper function computing the counter width.
- Sub-module `debounce_channel` holds the synchronizer, counter, level and pulse registers for one button.
- Top level instantiates `debounce_channel` NUM_BTN times in a generate loop. No shared logic between channels.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES = 4` and `NUM_BTN = 2`.
- **Reset:** hold `pmod = 2'b11` with `rst = 1` for 3 cycles. Then: `pressed = 00`, `press = 00`, `release = 00`, and outputs stay 0 for 20 cycles after release of `rst`.
- **Clean press:** drive `pmod[0] = 0` at edge 0 and hold. Then: `pressed[0]` rises at edge 5; `press[0] = 1` for exactly cycle 5–6; `release` stays 0; channel 1 is unaffected.
- **Glitch rejection:** from released, drive `pmod[0]` low for 3 cycles, high for 1, then low and hold. Then: no output before the final low run; `pressed[0]` rises 5 edges after the final low is sampled.
- **Release and simultaneous channels:** hold both buttons pressed, then drive `pmod = 2'b11` at the same edge. Then: `release = 2'b11` for one cycle at edge 5 and `pressed = 00`.
- **Reset while held:** with `pressed[1] = 1`, assert `rst` for 1 cycle and keep `pmod[1] = 0`. Then: `pressed[1] = 0` with no `release` pulse; a new `press[1]` pulse arrives 5 edges after `rst` deasserts.
- **Long hold:** hold `pmod[0] = 0` for 100 cycles. Then: exactly one `press[0]` pulse and `pressed[0]` stays 1 throughout.
